// File: rtl/acc_sequencer.sv
// Control sequencer for the 8-bit accumulator datapath.
// Drives fetch, ALU control, accumulator/output strobes, pc and halt.
module acc_sequencer #(
   parameter int PC_W   = 4,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic [DATA_W-1:0] instr,
   input  logic              instr_valid,
   input  logic              acc_zero,
   output logic [PC_W-1:0]   pc,
   output logic              instr_req,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_imm,
   output logic              acc_enable,
   output logic              out_enable,
   output logic              halted,
   output logic              illegal,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      WRITEBACK = 3'd3,
      HALTED    = 3'd4
   } state_e;

   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_OUT  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_e            state_q;
   logic [3:0]        op_q;
   logic [3:0]        arg_q;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_d;
   logic [PC_W-1:0]   tgt;
   logic [PC_W+3:0]   arg_ext;
   logic              take_q;
   logic [2:0]        alu_op_q;
   logic [DATA_W-1:0] alu_imm_q;
   logic              acc_en_q;
   logic              out_en_q;
   logic              halt_q;
   logic              ill_q;
   logic              is_alu;
   logic              is_bad;

   // ALU opcodes 1..7 map onto ALU codes 0..6; everything else passes.
   function automatic logic [2:0] alu_code(input logic [3:0] op);
      if (op >= 4'h1 && op <= 4'h7) return 3'(op - 4'h1);
      return 3'b000;
   endfunction

   assign arg_ext = {{PC_W{1'b0}}, arg_q};
   assign tgt     = arg_ext[PC_W-1:0];
   assign pc_d    = take_q ? tgt : pc_q + PC_W'(1);
   assign is_alu  = (op_q >= 4'h1) && (op_q <= 4'h7);
   assign is_bad  = (op_q >= 4'hB) && (op_q <= 4'hE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         op_q      <= '0;
         arg_q     <= '0;
         pc_q      <= '0;
         take_q    <= 1'b0;
         alu_op_q  <= '0;
         alu_imm_q <= '0;
         acc_en_q  <= 1'b0;
         out_en_q  <= 1'b0;
         halt_q    <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         acc_en_q <= 1'b0;
         out_en_q <= 1'b0;
         unique case (state_q)
            FETCH: begin
               if (run && instr_valid) begin
                  op_q      <= instr[DATA_W-1 -: 4];
                  arg_q     <= instr[3:0];
                  alu_op_q  <= alu_code(instr[DATA_W-1 -: 4]);
                  alu_imm_q <= DATA_W'(instr[3:0]);
                  state_q   <= DECODE;
               end
            end
            DECODE: begin
               if (is_bad) ill_q <= 1'b1;
               state_q <= EXECUTE;
            end
            EXECUTE: begin
               if (op_q == OP_HALT) begin
                  halt_q  <= 1'b1;
                  state_q <= HALTED;
               end else begin
                  take_q   <= (op_q == OP_JMP) ||
                              (op_q == OP_JZ && acc_zero);
                  acc_en_q <= is_alu;
                  out_en_q <= (op_q == OP_OUT);
                  state_q  <= WRITEBACK;
               end
            end
            WRITEBACK: begin
               pc_q    <= pc_d;
               state_q <= FETCH;
            end
            HALTED: state_q <= HALTED;
            default: state_q <= FETCH;
         endcase
      end
   end

   // Request is masked by reset so every output reads 0 while it is held.
   assign instr_req  = (state_q == FETCH) & run & ~reset;
   assign pc         = pc_q;
   assign alu_op     = alu_op_q;
   assign alu_imm    = alu_imm_q;
   assign acc_enable = acc_en_q;
   assign out_enable = out_en_q;
   assign halted     = halt_q;
   assign illegal    = ill_q;
   assign state      = state_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: instruction-level model
// compared every cycle plus directed literal checks.
module tb_acc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [7:0] instr;
   logic       iv;
   logic       az;
   logic [3:0] pc;
   logic       instr_req;
   logic [2:0] alu_op;
   logic [7:0] alu_imm;
   logic       acc_enable;
   logic       out_enable;
   logic       halted;
   logic       illegal;
   logic [2:0] state;

   always #5 clk = ~clk;

   acc_sequencer #(.PC_W(4), .DATA_W(8)) dut (
      .clock      (clk),
      .reset      (rst),
      .run        (run),
      .instr      (instr),
      .instr_valid(iv),
      .acc_zero   (az),
      .pc         (pc),
      .instr_req  (instr_req),
      .alu_op     (alu_op),
      .alu_imm    (alu_imm),
      .acc_enable (acc_enable),
      .out_enable (out_enable),
      .halted     (halted),
      .illegal    (illegal),
      .state      (state)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Instruction-level model: phase within the current instruction
   // (0 waiting for fetch, 1..3 after acceptance, 4 halted).
   int         m_ph;
   logic [3:0] m_pc, m_op, m_arg;
   logic [2:0] m_aop;
   logic       m_ill, m_take;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_pc = 0; m_op = 0; m_arg = 0;
         m_aop = 0; m_ill = 0; m_take = 0;
      end else begin
         case (m_ph)
            0: if (run && iv) begin
                  m_op  = instr[7:4];
                  m_arg = instr[3:0];
                  m_aop = (m_op >= 1 && m_op <= 7) ? 3'(m_op - 4'd1) : 3'd0;
                  m_ph  = 1;
               end
            1: begin
                  if (m_op >= 4'hB && m_op <= 4'hE) m_ill = 1'b1;
                  m_ph = 2;
               end
            2: begin
                  m_take = (m_op == 4'h8) || (m_op == 4'h9 && az);
                  m_ph   = (m_op == 4'hF) ? 4 : 3;
               end
            3: begin
                  m_pc = m_take ? m_arg : m_pc + 4'd1;
                  m_ph = 0;
               end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      logic alu;
      alu = (m_op >= 4'h1) && (m_op <= 4'h7);
      chk("state", state, m_ph);
      chk("pc", pc, m_pc);
      chk("instr_req", instr_req, !rst && m_ph == 0 && run);
      chk("alu_op", alu_op, m_aop);
      chk("alu_imm", alu_imm, {4'h0, m_arg});
      chk("acc_enable", acc_enable, m_ph == 3 && alu);
      chk("out_enable", out_enable, m_ph == 3 && m_op == 4'hA);
      chk("halted", halted, m_ph == 4);
      chk("illegal", illegal, m_ill);
   end

   logic [7:0] mem [16];
   bit         use_mem;
   int         n_acc, n_out, n_both;
   logic [5:0] op_log;

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   endtask

   task automatic start_prog();
      @(posedge clk); #1;
      rst = 1; run = 0; iv = 0; az = 0; instr = 0;
      @(posedge clk); #1;
      rst = 0; run = 1; iv = 1; use_mem = 1;
      instr = mem[0];
      n_acc = 0; n_out = 0; n_both = 0; op_log = 6'b111111;
   endtask

   task automatic go(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (use_mem) instr = mem[pc];
         @(negedge clk);
         if (acc_enable) begin
            n_acc++;
            op_log = {op_log[2:0], alu_op};
         end
         if (out_enable) n_out++;
         if (acc_enable && out_enable) n_both++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_cyc, acc_cnt, i, st_bad, hold_bad;
      rst = 1; run = 0; iv = 0; az = 0; instr = 0; use_mem = 0;
      clear_mem();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_flags", {acc_enable, out_enable, halted, illegal, instr_req}, 0);

      // LDI 5 straight out of reset
      rst = 0; run = 1; instr = 8'h15; iv = 1;
      @(negedge clk);
      chk("t1_req", instr_req, 1);
      @(posedge clk); #1;
      iv = 0;
      @(negedge clk);
      chk("t1_decode", state, 1);
      chk("t1_imm", alu_imm, 8'h05);
      chk("t1_op", alu_op, 3'b000);
      acc_cyc = 0; acc_cnt = 0;
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         if (acc_enable) begin acc_cyc = k; acc_cnt++; end
      end
      chk("t1_acc_cycle", acc_cyc, 4);
      chk("t1_acc_pulses", acc_cnt, 1);
      chk("t1_pc", pc, 1);

      // LDI 3, ADDI 4, OUT, HALT
      clear_mem();
      mem[0] = 8'h13; mem[1] = 8'h24; mem[2] = 8'hA0; mem[3] = 8'hF0;
      start_prog();
      i = 0;
      while (!halted && i < 40) begin go(1); i++; end
      chk("t2_halted", halted, 1);
      chk("t2_acc_pulses", n_acc, 2);
      chk("t2_alu_ops", op_log, 6'b000_001);
      chk("t2_out_pulses", n_out, 1);
      chk("t2_overlap", n_both, 0);
      chk("t2_pc", pc, 3);
      hold_bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (k == 10) begin @(posedge clk); #1; run = 0; end
         go(1);
         if (!halted || pc != 4'd3 || state != 3'd4 ||
             acc_enable || out_enable) hold_bad++;
      end
      chk("t2_hold", hold_bad, 0);

      // Branches
      clear_mem(); mem[0] = 8'h97;
      start_prog(); az = 1; go(4);
      chk("t3_jz_taken", pc, 7);
      start_prog(); az = 0; go(4);
      chk("t3_jz_not", pc, 1);
      clear_mem(); mem[0] = 8'h8C;
      start_prog(); go(4);
      chk("t3_jmp", pc, 12);

      // pc wrap
      clear_mem(); mem[0] = 8'h8F;
      start_prog(); go(4);
      chk("t4_pc15", pc, 15);
      go(4);
      chk("t4_wrap", pc, 0);

      // Illegal opcode is sticky
      clear_mem(); mem[0] = 8'hB0; mem[1] = 8'h13;
      start_prog(); go(4);
      chk("t4_illegal", illegal, 1);
      chk("t4_ill_strobes", n_acc + n_out, 0);
      chk("t4_ill_pc", pc, 1);
      go(8);
      chk("t4_ill_sticky", illegal, 1);
      chk("t4_ill_ldi_acc", n_acc, 1);

      // Fetch stalls, run low
      clear_mem();
      start_prog(); iv = 0;
      st_bad = 0;
      repeat (3) begin
         go(1);
         if (state != 3'd0 || !instr_req) st_bad++;
      end
      chk("t5_stall", st_bad, 0);
      iv = 1; go(1);
      chk("t5_accept", state, 1);
      iv = 0; go(3);
      chk("t5_back", state, 0);
      @(posedge clk); #1;
      run = 0; iv = 1;
      @(negedge clk);
      chk("t5_req_off", instr_req, 0);
      @(posedge clk); #1;
      iv = 0;
      @(negedge clk);
      chk("t5_park", state, 0);
      @(posedge clk); #1;
      run = 1; iv = 1;
      @(negedge clk);
      @(posedge clk); #1;
      run = 0; iv = 0;
      go(3);
      chk("t5_run_drop_pc", pc, 2);
      chk("t5_run_drop_st", state, 0);

      // Async reset in EXECUTE of ADDI
      clear_mem(); mem[0] = 8'h24;
      start_prog(); go(2);
      chk("t6_in_exec", state, 2);
      #1 rst = 1;
      #1;
      chk("t6_zero", {state, pc, alu_op, alu_imm, acc_enable,
                      out_enable, halted, illegal, instr_req}, 0);
      n_acc = 0;
      go(2);
      chk("t6_no_acc", n_acc, 0);
      @(posedge clk); #1;
      rst = 0; instr = mem[0]; iv = 1;
      chk("t6_restart_pc", pc, 0);
      n_acc = 0;
      go(4);
      chk("t6_rerun_acc", n_acc, 1);
      chk("t6_rerun_pc", pc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
Multi-cycle control FSM that sequences the 8-bit accumulator datapath of the CPU core. It fetches one 8-bit instruction per pass from instruction memory and decodes it. It drives the ALU operation and operand, pulses the accumulator enable, and manages the program counter, jumps, output strobes and halt. It is a pure controller: accumulator storage and the ALU sit outside it.

Parameters:
PC_W, 4, program counter width; jump targets are the 4-bit operand, zero-extended or truncated to PC_W.
DATA_W, 8, instruction and immediate width; opcode is [DATA_W-1:DATA_W-4], operand is [3:0].

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
run  in  1  level; 0 parks the FSM in FETCH with no request.
instr  in  DATA_W  instruction word at pc, valid when instr_valid=1.
instr_valid  in  1  memory acknowledge; sampled only while instr_req=1.
acc_zero  in  1  accumulator out == 0.
pc  out  PC_W  program counter.
instr_req  out  1  fetch request.
alu_op  out  3  000 PASS, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT.
alu_imm  out  DATA_W  zero-extended operand nibble.
acc_enable  out  1  one-cycle accumulator load strobe.
out_enable  out  1  one-cycle output-port load strobe.
halted  out  1  high in HALTED.
illegal  out  1  sticky; set by an undefined opcode.
state  out  3  FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALTED=4.

Behaviour:
- Reset: all outputs 0, state=FETCH, IR=0. Reset is asynchronous and takes effect mid-instruction, with no strobe emitted afterward.
- All outputs are registered. instr_req is the only output decoded from state: instr_req = (state==FETCH) & run.
- FETCH: wait. On a posedge with instr_req & instr_valid, latch instr into IR and go to DECODE. instr_valid is ignored when run=0.
- DECODE: 1 cycle. Set alu_op and alu_imm from IR, then go to EXECUTE. alu_op and alu_imm hold until the next DECODE.
- EXECUTE: 1 cycle. The ALU settles. Branches are resolved here, with acc_zero sampled on this cycle. Next state is WRITEBACK.
- WRITEBACK: 1 cycle, then FETCH.
  - acc_enable=1 for ALU opcodes.
  - out_enable=1 for OUT.
  - pc <= target, or pc+1 otherwise.
- Latency: 4 cycles per instruction when instr_valid is already high in FETCH.
- Opcodes:
  - 0x0 NOP
  - 0x1 LDI (PASS)
  - 0x2 ADDI
  - 0x3 SUBI
  - 0x4 ANDI
  - 0x5 ORI
  - 0x6 XORI
  - 0x7 NOT
  - 0x8 JMP: pc <= imm.
  - 0x9 JZ: pc <= imm if acc_zero, else pc+1.
  - 0xA OUT
  - 0xF HALT
  - 0xB-0xE: execute as NOP and set illegal.
- HALT: in EXECUTE go directly to HALTED. pc is not incremented. halted=1. The FSM leaves HALTED only on reset, and run is ignored there.
- pc wraps from 2^PC_W-1 to 0.
- run dropping outside FETCH does not abort. The current instruction completes, then the FSM parks.
- acc_enable and out_enable are never high together, and never high outside WRITEBACK.

Test Plan:
- Reset held, then released with run=1 and instr=0x15 (LDI 5) valid → DECODE next cycle with alu_op=000, alu_imm=0x05. acc_enable=1 exactly in cycle 4, pc=1 after it.
- Program LDI 3, ADDI 4, OUT, HALT (0x13,0x24,0xA0,0xF0) → alu_op sequence 000,001 with two acc_enable pulses. out_enable pulses once in the OUT WRITEBACK, then halted=1 with pc=3, held for 20 cycles.
- JZ 0x97 with acc_zero=1 → pc=7. Repeat with acc_zero=0 → pc=1. JMP 0x8C → pc=12.
- pc=15 executing NOP → pc=0. Opcode 0xB0 → illegal=1, no strobes, stays 1 through later legal instructions.
- instr_valid withheld 3 cycles in FETCH → state stays 0 and instr_req=1. run=0 → instr_req=0 and a pulse on instr_valid is ignored.
- Reset asserted in EXECUTE of ADDI → all outputs 0 within the same cycle, no acc_enable, restart at pc=0.
